// File: rtl/uart_rx_pkg.sv
// Shared types and frame-format defaults for the UART receive path.
package uart_rx_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; reset value is selectable.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start validation, mid-bit LSB-first sampling, optional parity,
// stop check, and a valid/ready output that holds one word and flags overrun.
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample
// START     | counting to the start-bit centre to reject glitches
// DATA      | sampling data bits at each bit centre
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, delivering or flagging the frame
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);
  localparam bit            HAS_PAR = (PARITY_EN != 0);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 deliver, stop_bad;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TC_MID) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_d     = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TC_END) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BC_LAST) state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_q == TC_END) begin
            par_bad_d = (^shift_q) ^ rx_s ^ PAR_ODD;
            tick_d    = '0;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TC_END) begin
            tick_d = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pending word is only replaced when it is consumed in the same cycle.
  always_comb begin
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (deliver) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        perr_d  = par_bad_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
